// File: rtl/reg_file_bank.sv
// DEPTH x WIDTH register bank: one byte-lane-masked write port, two registered
// read ports with write-to-read bypass, synchronous bulk clear, sticky address error.
module reg_file_bank #(
  parameter int                 WIDTH     = 8,
  parameter int                 DEPTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                NB        = WIDTH / 8,
  localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ena_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [NB-1:0]    be_i,
  input  logic             clr_i,
  input  logic [AW-1:0]    raddr_a_i,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [WIDTH-1:0] ra_o,
  output logic [WIDTH-1:0] rb_o,
  output logic             err_o
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] addr);
    return ({1'b0, addr} < DEPTH_W);
  endfunction

  function automatic logic [WIDTH-1:0] lane_merge(
    input logic [WIDTH-1:0] old_v,
    input logic [WIDTH-1:0] new_v,
    input logic [NB-1:0]    be
  );
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < NB; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             err_q, err_d;

  logic             wr_ok_s;
  logic             wr_bad_s;
  logic             rd_a_bad_s;
  logic             rd_b_bad_s;
  logic [WIDTH-1:0] wr_old_s;
  logic [WIDTH-1:0] wr_merged_s;
  logic [WIDTH-1:0] rd_a_s;
  logic [WIDTH-1:0] rd_b_s;

  // Address decode, lane merge and read muxes; the read path sees the merged
  // post-write value so a same-edge write is bypassed to either port.
  always_comb begin
    wr_old_s = RESET_VAL;
    rd_a_s   = '0;
    rd_b_s   = '0;
    for (int e = 0; e < DEPTH; e++) begin
      wr_old_s = (waddr_i == AW'(e))   ? mem_q[e] : wr_old_s;
      rd_a_s   = (raddr_a_i == AW'(e)) ? mem_q[e] : rd_a_s;
      rd_b_s   = (raddr_b_i == AW'(e)) ? mem_q[e] : rd_b_s;
    end

    wr_merged_s = lane_merge(wr_old_s, data_i, be_i);
    wr_ok_s     = ena_i && !clr_i && in_range(waddr_i);
    wr_bad_s    = ena_i && !in_range(waddr_i);
    rd_a_bad_s  = !in_range(raddr_a_i);
    rd_b_bad_s  = !in_range(raddr_b_i);

    if (wr_ok_s && (waddr_i == raddr_a_i)) begin
      rd_a_s = wr_merged_s;
    end else begin
      rd_a_s = rd_a_s;
    end
    if (wr_ok_s && (waddr_i == raddr_b_i)) begin
      rd_b_s = wr_merged_s;
    end else begin
      rd_b_s = rd_b_s;
    end
  end

  // Next-state for storage, read registers and error flag; clear overrides everything.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = mem_q[e];
    end
    ra_d  = rd_a_s;
    rb_d  = rd_b_s;
    err_d = err_q | wr_bad_s | rd_a_bad_s | rd_b_bad_s;

    if (clr_i) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_d[e] = RESET_VAL;
      end
      ra_d  = RESET_VAL;
      rb_d  = RESET_VAL;
      err_d = 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_d[e] = (wr_ok_s && (waddr_i == AW'(e))) ? wr_merged_s : mem_q[e];
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= RESET_VAL;
      end
      ra_q  <= RESET_VAL;
      rb_q  <= RESET_VAL;
      err_q <= 1'b0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= mem_d[e];
      end
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      err_q <= err_d;
    end
  end

  assign ra_o  = ra_q;
  assign rb_o  = rb_q;
  assign err_o = err_q;

endmodule
